// File: rtl/cdc_hs_pkg.sv
// Shared types and constants for the four-phase handshake arbiter.
package cdc_hs_pkg;

    // Handshake controller states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACK_HI = 2'd1,
        ACK_LO = 2'd2
    } hs_state_t;

    // Shallowest synchronizer considered safe for the ACK crossing
    localparam int unsigned MIN_SYNC_STAGES = 2;

endpackage

// File: rtl/cdc_sync_bit.sv
// Single-bit flop-chain synchronizer with asynchronous active-low reset.
// Depth requests below MIN_SYNC_STAGES are raised to MIN_SYNC_STAGES.
module cdc_sync_bit
    import cdc_hs_pkg::*;
#(
    parameter int unsigned STAGES = MIN_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    localparam int unsigned DEPTH = (STAGES < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : STAGES;

    (* ASYNC_REG = "TRUE" *) logic [DEPTH-1:0] sync_ff;

    // Shift the asynchronous input through the chain; the last stage is the safe copy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_ff <= '0;
        end else begin
            sync_ff <= {sync_ff[DEPTH-2:0], d};
        end
    end

    assign q = sync_ff[DEPTH-1];

endmodule

// File: rtl/cdc_hs_arbiter.sv
// Round-robin arbiter feeding a four-phase REQ/ACK handshake into another
// clock domain. ACK is synchronized before use; a stale ACK blocks grants.
// Optional ACK-wait timeout is enabled by defining CDC_HS_TIMEOUT_EN.
module cdc_hs_arbiter
    import cdc_hs_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                      CLK_100_i,
    input  logic                      RST_N_i,
    input  logic [NUM_REQ-1:0]        REQ_VALID_i,
    input  logic [NUM_REQ*DATA_W-1:0] REQ_DATA_i,
    output logic [NUM_REQ-1:0]        REQ_READY_o,
    output logic                      HS_REQ_o,
    output logic [DATA_W-1:0]         HS_DATA_o,
    input  logic                      HS_ACK_i,
    output logic                      BUSY_o,
    output logic                      TIMEOUT_o
);

    localparam int unsigned GW = $clog2(NUM_REQ);

    if (TIMEOUT_CYCLES < 1) begin : g_tmo_check
        $error("cdc_hs_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

    hs_state_t         state;
    logic [GW-1:0]     last_grant;
    logic [GW-1:0]     winner;
    logic              found;
    logic              grant;
    logic              ack_s;
    logic              hs_req;
    logic [DATA_W-1:0] hs_data;
    logic [DATA_W-1:0] win_data;

    cdc_sync_bit #(
        .STAGES(SYNC_STAGES)
    ) u_ack_sync (
        .clk  (CLK_100_i),
        .rst_n(RST_N_i),
        .d    (HS_ACK_i),
        .q    (ack_s)
    );

    // Round-robin search starting one past the last grant, wrapping at NUM_REQ
    always_comb begin
        int unsigned idx;
        logic [GW-1:0] cand;
        winner = last_grant;
        found  = 1'b0;
        idx    = 0;
        cand   = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = int'(last_grant) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            cand = GW'(idx);
            if (!found && REQ_VALID_i[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    // Select the winning requester's payload slice
    always_comb begin
        win_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (winner == GW'(i)) begin
                win_data = REQ_DATA_i[i*DATA_W +: DATA_W];
            end
        end
    end

    assign grant       = (state == IDLE) && !ack_s && found;
    assign REQ_READY_o = grant ? (NUM_REQ'(1) << winner) : '0;
    assign HS_REQ_o    = hs_req;
    assign HS_DATA_o   = hs_data;
    assign BUSY_o      = (state != IDLE);

`ifdef CDC_HS_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_cnt_next;
    logic             timeout;

    assign wait_cnt_next = wait_cnt + 1'b1;
    assign TIMEOUT_o     = timeout;
`else
    assign TIMEOUT_o = 1'b0;
`endif

    // Handshake controller: grant, wait for ACK high, wait for ACK low
    always_ff @(posedge CLK_100_i or negedge RST_N_i) begin
        if (!RST_N_i) begin
            state      <= IDLE;
            hs_req     <= 1'b0;
            hs_data    <= '0;
            last_grant <= GW'(NUM_REQ - 1);
`ifdef CDC_HS_TIMEOUT_EN
            wait_cnt   <= '0;
            timeout    <= 1'b0;
`endif
        end else begin
`ifdef CDC_HS_TIMEOUT_EN
            timeout <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (grant) begin
                        hs_data    <= win_data;
                        last_grant <= winner;
                        hs_req     <= 1'b1;
                        state      <= ACK_HI;
`ifdef CDC_HS_TIMEOUT_EN
                        wait_cnt   <= '0;
`endif
                    end
                end
                ACK_HI: begin
                    if (ack_s) begin
                        hs_req <= 1'b0;
                        state  <= ACK_LO;
                    end
`ifdef CDC_HS_TIMEOUT_EN
                    else if (wait_cnt_next == CNT_W'(TIMEOUT_CYCLES)) begin
                        timeout <= 1'b1;
                        hs_req  <= 1'b0;
                        state   <= ACK_LO;
                    end else begin
                        wait_cnt <= wait_cnt_next;
                    end
`endif
                end
                ACK_LO: begin
                    if (!ack_s) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state  <= IDLE;
                    hs_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cdc_hs_arbiter.sv
// Directed-plus-random bench for cdc_hs_arbiter. Grant order is predicted by
// a round-robin model over the requested valid pattern; handshake latencies
// follow from the ACK synchronizer depth.
module tb_cdc_hs_arbiter;

    localparam int unsigned N   = 4;
    localparam int unsigned W   = 8;
    localparam int unsigned SS  = 2;
    localparam int unsigned TMO = 16;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   valid;
    logic [N*W-1:0] data;
    logic [N-1:0]   ready;
    logic           hs_req;
    logic [W-1:0]   hs_data;
    logic           ack;
    logic           busy;
    logic           timeout;

    int unsigned    vectors     = 0;
    int unsigned    miscompares = 0;
    int unsigned    last_m;
    logic [W-1:0]   pay [N];

    always #5 clk = ~clk;

    cdc_hs_arbiter #(
        .NUM_REQ       (N),
        .DATA_W        (W),
        .SYNC_STAGES   (SS),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .CLK_100_i  (clk),
        .RST_N_i    (rst_n),
        .REQ_VALID_i(valid),
        .REQ_DATA_i (data),
        .REQ_READY_o(ready),
        .HS_REQ_o   (hs_req),
        .HS_DATA_o  (hs_data),
        .HS_ACK_i   (ack),
        .BUSY_o     (busy),
        .TIMEOUT_o  (timeout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input logic [N-1:0] v);
        valid = v;
        for (int i = 0; i < N; i++) data[i*W +: W] = pay[i];
    endtask

    task automatic randomize_pay();
        for (int i = 0; i < N; i++) pay[i] = W'($urandom);
    endtask

    // First valid index after 'last', wrapping; N means nobody is valid
    function automatic int unsigned rr_pick(input int unsigned last, input logic [N-1:0] v);
        int unsigned j;
        for (int unsigned k = 1; k <= N; k++) begin
            j = (last + k) % N;
            if (((v >> j) & N'(1)) != '0) return j;
        end
        return N;
    endfunction

    function automatic logic [31:0] onehot(input int unsigned w);
        logic [31:0] one;
        one = 32'd1;
        return (w == N) ? 32'd0 : (one << w);
    endfunction

    // Run REQ high -> ACK high -> REQ low -> ACK low -> IDLE
    task automatic handshake(input logic [W-1:0] exp_data, input string tag);
        int unsigned n;
        repeat (3) begin
            tick();
            chk({tag, "/req_held"}, 32'(hs_req), 32'd1);
            chk({tag, "/data_held"}, 32'(hs_data), 32'(exp_data));
            chk({tag, "/no_ready_hi"}, 32'(ready), 32'd0);
        end
        ack = 1'b1;
        n = 0;
        while (hs_req !== 1'b0 && n < 10) begin
            tick();
            n++;
        end
        chk({tag, "/ack_to_req_fall"}, n, SS + 1);
        repeat (3) begin
            tick();
            chk({tag, "/busy_lo_phase"}, 32'(busy), 32'd1);
            chk({tag, "/no_ready_lo"}, 32'(ready), 32'd0);
        end
        ack = 1'b0;
        n = 0;
        while (busy !== 1'b0 && n < 10) begin
            tick();
            n++;
        end
        chk({tag, "/ackdrop_to_idle"}, n, SS + 1);
        chk({tag, "/data_after"}, 32'(hs_data), 32'(exp_data));
    endtask

    // One arbitration round for valid pattern v with the current payloads
    task automatic xfer(input logic [N-1:0] v, input string tag);
        int unsigned  w;
        logic [W-1:0] exp_data;
        apply(v);
        #1;
        w = rr_pick(last_m, v);
        chk({tag, "/ready"}, 32'(ready), onehot(w));
        if (w == N) begin
            tick();
            chk({tag, "/stay_idle"}, 32'(busy), 32'd0);
            apply('0);
            return;
        end
        tick();
        chk({tag, "/req_rise"}, 32'(hs_req), 32'd1);
        chk({tag, "/data"}, 32'(hs_data), 32'(pay[w]));
        chk({tag, "/busy"}, 32'(busy), 32'd1);
        chk({tag, "/ready_pulse"}, 32'(ready), 32'd0);
        last_m   = w;
        exp_data = pay[w];
        // Winner presents a new payload; the channel must keep the latched one
        pay[w] = ~pay[w];
        apply(v);
        handshake(exp_data, tag);
        apply('0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int unsigned  n;
        int unsigned  w;
        logic [W-1:0] exp_data;

        rst_n = 1'b0;
        ack   = 1'b0;
        for (int i = 0; i < N; i++) pay[i] = '0;
        apply('0);
        last_m = N - 1;
        repeat (3) tick();
        chk("reset/hs_req", 32'(hs_req), 32'd0);
        chk("reset/hs_data", 32'(hs_data), 32'd0);
        chk("reset/busy", 32'(busy), 32'd0);
        chk("reset/timeout", 32'(timeout), 32'd0);
        chk("reset/ready", 32'(ready), 32'd0);
        rst_n = 1'b1;
        tick();

        // All requesters valid: expect 0,1,2,3,0
        for (int r = 0; r < 5; r++) begin
            randomize_pay();
            xfer('1, "all_valid");
        end

        // Single requester 2 with 0xA5
        randomize_pay();
        pay[2] = 8'hA5;
        xfer(4'b0100, "only_r2");

        // Random valid patterns and payloads
        for (int r = 0; r < 30; r++) begin
            randomize_pay();
            xfer(N'($urandom_range(0, (1 << N) - 1)), "random");
        end

        // Stale ACK held through reset release
        rst_n = 1'b0;
        ack   = 1'b1;
        tick();
        tick();
        chk("stale/reset_busy", 32'(busy), 32'd0);
        rst_n  = 1'b1;
        last_m = N - 1;
        repeat (4) tick();
        randomize_pay();
        apply('1);
        #1;
        repeat (5) begin
            chk("stale/no_ready", 32'(ready), 32'd0);
            tick();
        end
        chk("stale/still_idle", 32'(busy), 32'd0);
        ack = 1'b0;
        #1;
        chk("stale/no_ready_at_drop", 32'(ready), 32'd0);
        n = 0;
        while (ready === '0 && n < 10) begin
            tick();
            n++;
        end
        chk("stale/drop_to_ready", n, SS);
        w = rr_pick(last_m, '1);
        chk("stale/ready", 32'(ready), onehot(w));
        tick();
        chk("stale/req_rise", 32'(hs_req), 32'd1);
        chk("stale/data", 32'(hs_data), 32'(pay[w]));
        last_m   = w;
        exp_data = pay[w];
        apply('0);
        handshake(exp_data, "stale");

        // Reset while waiting for ACK high
        randomize_pay();
        apply(4'b0010);
        tick();
        chk("midrst/req_rise", 32'(hs_req), 32'd1);
        tick();
        rst_n = 1'b0;
        #1;
        chk("midrst/req_async", 32'(hs_req), 32'd0);
        chk("midrst/busy_async", 32'(busy), 32'd0);
        chk("midrst/data_async", 32'(hs_data), 32'd0);
        apply('0);
        tick();
        rst_n  = 1'b1;
        last_m = N - 1;
        tick();
        randomize_pay();
        xfer(4'b0110, "after_rst");

`ifdef CDC_HS_TIMEOUT_EN
        // ACK never answers: abort after TMO cycles in ACK_HI
        randomize_pay();
        apply(4'b1000);
        #1;
        w = rr_pick(last_m, 4'b1000);
        tick();
        chk("tmo/req_rise", 32'(hs_req), 32'd1);
        last_m = w;
        apply('0);
        for (int unsigned k = 1; k <= TMO + 1; k++) begin
            tick();
            chk("tmo/pulse", 32'(timeout), (k == TMO) ? 32'd1 : 32'd0);
            chk("tmo/req", 32'(hs_req), (k < TMO) ? 32'd1 : 32'd0);
        end
        chk("tmo/idle", 32'(busy), 32'd0);
        randomize_pay();
        xfer(4'b1111, "after_tmo");
`else
        // ACK never answers: wait indefinitely
        randomize_pay();
        apply(4'b1000);
        #1;
        w = rr_pick(last_m, 4'b1000);
        tick();
        chk("notmo/req_rise", 32'(hs_req), 32'd1);
        last_m   = w;
        exp_data = pay[w];
        apply('0);
        repeat (1000) begin
            tick();
            chk("notmo/req", 32'(hs_req), 32'd1);
            chk("notmo/timeout", 32'(timeout), 32'd0);
        end
        handshake(exp_data, "notmo");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cdc_hs_arbiter.md
CDC_HS_ARBITER -- requirements
Module: cdc_hs_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing the channel (2..8).
REQ-002 Parameter DATA_W, default 8: payload width in bits.
REQ-003 Parameter SYNC_STAGES, default 2: ACK synchronizer depth (minimum 2).
REQ-004 Parameter TIMEOUT_CYCLES, default 255: ACK-wait limit; used only when CDC_HS_TIMEOUT_EN is defined.
REQ-005 CLK_100_i  input  1  the single source-domain clock; all state changes on its rising edge.
REQ-006 RST_N_i  input  1  reset, asynchronous assert, active-low.
REQ-007 REQ_VALID_i  input  NUM_REQ  per-requester payload valid.
REQ-008 REQ_DATA_i  input  NUM_REQ*DATA_W  per-requester payload; slice i is bits [i*DATA_W +: DATA_W].
REQ-009 REQ_READY_o  output  NUM_REQ  one-hot payload-accept strobe.
REQ-010 HS_REQ_o  output  1  four-phase request to the destination domain.
REQ-011 HS_DATA_o  output  DATA_W  payload, stable whenever HS_REQ_o=1.
REQ-012 HS_ACK_i  input  1  four-phase acknowledge, asynchronous to CLK_100_i.
REQ-013 BUSY_o  output  1  high in every state except IDLE.
REQ-014 TIMEOUT_o  output  1  one-cycle abort pulse.

Function
REQ-015 HS_ACK_i shall pass through a SYNC_STAGES-deep flop chain (ack_s) before any use.
REQ-016 FSM states: IDLE, ACK_HI (wait ack_s=1), ACK_LO (wait ack_s=0).
REQ-017 REQ_READY_o[i] shall be combinational: 1 only in IDLE, only for the round-robin winner i, only if REQ_VALID_i[i]=1.
REQ-018 Round-robin: search starts at last_grant+1 modulo NUM_REQ; the first valid index wins.
REQ-019 On a clock edge with any READY: latch that requester's slice into HS_DATA_o, update last_grant, set HS_REQ_o=1, and go to ACK_HI.
REQ-020 ACK_HI, ack_s=1: clear HS_REQ_o and go to ACK_LO.
REQ-021 ACK_LO, ack_s=0: go to IDLE; a new grant is permitted on the following edge.
REQ-022 IDLE with ack_s=1 shall not grant; a stale ACK shall block new transfers.
REQ-023 HS_DATA_o shall change only on grant edges.
REQ-024 HS_REQ_o shall be driven directly from a flop.
REQ-025 A requester dropping REQ_VALID_i while not granted shall lose nothing; no grant is ever revoked.

Reset
REQ-026 Asynchronous reset shall force IDLE, HS_REQ_o=0, HS_DATA_o=0, ack_s chain=0, TIMEOUT_o=0 and last_grant=NUM_REQ-1 (requester 0 first).
REQ-027 Reset mid-handshake shall abandon the transfer; after release the IDLE stale-ACK rule (REQ-022) applies.

Configuration
REQ-028 Macro CDC_HS_TIMEOUT_EN defined: a counter shall run in ACK_HI and clear on entry.
REQ-029 With CDC_HS_TIMEOUT_EN, when the counter reaches TIMEOUT_CYCLES: pulse TIMEOUT_o for 1 cycle, clear HS_REQ_o, and go to ACK_LO.
REQ-030 Macro undefined: no counter, TIMEOUT_o tied 0, and ACK_HI waits indefinitely.

Structure
REQ-031 Package cdc_hs_pkg shall hold the state enum typedef and the constant MIN_SYNC_STAGES=2.
REQ-032 Sub-module cdc_sync_bit shall hold the parameterized synchronizer, with ASYNC_REG="TRUE" on every stage and asynchronous active-low reset.

Verification
REQ-033 NUM_REQ=4, all valid from reset, ACK echoed 3 cycles after HS_REQ_o edges -> grants in order 0,1,2,3,0; each HS_DATA_o matches the winner's slice.
REQ-034 Only requester 2 valid, data 0xA5 -> READY[2] pulses 1 cycle; next cycle HS_REQ_o=1 with HS_DATA_o=0xA5; no grant until ack_s returns to 0.
REQ-035 HS_ACK_i held 1 at reset release, valid asserted -> no READY until ACK drops plus SYNC_STAGES cycles.
REQ-036 RST_N_i asserted in ACK_HI -> HS_REQ_o=0 and BUSY_o=0 immediately, without waiting for a clock edge.
REQ-037 CDC_HS_TIMEOUT_EN, TIMEOUT_CYCLES=16, ACK never returns -> TIMEOUT_o pulses exactly 16 cycles after HS_REQ_o rises, then HS_REQ_o=0 and IDLE follows.
REQ-038 Macro undefined, ACK never returns -> HS_REQ_o stays 1 and TIMEOUT_o stays 0 for 1000 cycles.
